lc3b_mem_unit: RTL and testbench

- Parametrised memory-access unit that replaces the fixed MAR/MDR path and byte handling of the multicycle LC-3b datapath.
- Takes one load/store request at a time from the control/datapath side and runs the memory handshake. Supported operations:
  - word and byte loads/stores;
  - indirect loads/stores (LDI/STI), which perform two memory accesses.
- Sits between the datapath and the memory/cache port.

---
 rtl/lc3b_mem_unit_pkg.sv | 29 ++
 rtl/lc3b_mem_unit_lane.sv | 25 ++
 rtl/lc3b_mem_unit.sv | 126 ++++++++++++
 tb/tb_lc3b_mem_unit.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3b_mem_unit_pkg.sv
// Shared LC-3b type definitions: memory-unit operation codes and FSM states.
package lc3b_types;

  typedef enum logic [2:0] {
    LDW = 3'd0,
    LDB = 3'd1,
    STW = 3'd2,
    STB = 3'd3,
    LDI = 3'd4,
    STI = 3'd5
  } lc3b_memop;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PTR_RD = 3'd1,
    READ   = 3'd2,
    WRITE  = 3'd3,
    DONE   = 3'd4
  } lc3b_memstate;

  function automatic logic is_byte_op(input lc3b_memop op);
    return (op == LDB) || (op == STB);
  endfunction

  function automatic logic is_indirect(input lc3b_memop op);
    return (op == LDI) || (op == STI);
  endfunction

endpackage

// File: rtl/lc3b_mem_unit_lane.sv
// Byte-lane steering: load extract with sign extension, store replication, lane enables.
module mem_lane #(
  parameter int WIDTH = 16,
  localparam int LANES = WIDTH / 8,
  localparam int LANE_BITS = $clog2(LANES)
) (
  input  logic [LANE_BITS-1:0] lane,
  input  logic                 byte_op,
  input  logic [WIDTH-1:0]     rdata,
  input  logic [WIDTH-1:0]     wdata,
  output logic [WIDTH-1:0]     load_data,
  output logic [WIDTH-1:0]     store_data,
  output logic [LANES-1:0]     byte_en
);

  logic [7:0] sel_byte;

  always_comb begin
    sel_byte   = rdata[8*lane +: 8];
    load_data  = byte_op ? {{(WIDTH-8){sel_byte[7]}}, sel_byte} : rdata;
    store_data = byte_op ? {LANES{wdata[7:0]}} : wdata;
    byte_en    = byte_op ? (LANES'(1) << lane) : '1;
  end

endmodule

// File: rtl/lc3b_mem_unit.sv
// LC-3b memory-access unit: one request at a time, word/byte and indirect accesses.
module lc3b_mem_unit
  import lc3b_types::*;
#(
  parameter int WIDTH = 16,
  localparam int LANES = WIDTH / 8,
  localparam int LANE_BITS = $clog2(LANES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  lc3b_memop        req_op,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             resp_valid,
  output logic [WIDTH-1:0] resp_rdata,
  output logic [WIDTH-1:0] mem_address,
  output logic             mem_read,
  output logic             mem_write,
  output logic [LANES-1:0] mem_byte_enable,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_resp
);

  lc3b_memstate     state, state_next;
  lc3b_memop        op_r;
  logic [WIDTH-1:0] addr_r, wdata_r, ptr_r;
  logic [WIDTH-1:0] tgt_base, tgt_addr;
  logic [WIDTH-1:0] lane_load, lane_store;
  logic [LANES-1:0] lane_be;
  logic             byte_op;

  function automatic logic [WIDTH-1:0] word_align(input logic [WIDTH-1:0] a);
    return {a[WIDTH-1:LANE_BITS], {LANE_BITS{1'b0}}};
  endfunction

  // Indirect ops reach their target through the latched pointer.
  always_comb begin
    byte_op  = is_byte_op(op_r);
    tgt_base = is_indirect(op_r) ? ptr_r : addr_r;
    tgt_addr = byte_op ? tgt_base : word_align(tgt_base);
  end

  mem_lane #(.WIDTH(WIDTH)) u_lane (
    .lane       (tgt_base[LANE_BITS-1:0]),
    .byte_op    (byte_op),
    .rdata      (mem_rdata),
    .wdata      (wdata_r),
    .load_data  (lane_load),
    .store_data (lane_store),
    .byte_en    (lane_be)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_r       <= LDW;
      addr_r     <= '0;
      wdata_r    <= '0;
      ptr_r      <= '0;
      resp_rdata <= '0;
    end else begin
      if (state == IDLE && req_valid) begin
        op_r    <= req_op;
        addr_r  <= req_addr;
        wdata_r <= req_wdata;
      end
      if (state == PTR_RD && mem_resp) ptr_r <= mem_rdata;
      if (state == READ && mem_resp) resp_rdata <= lane_load;
    end
  end

  // Strobes and bus outputs depend on the registered state only.
  always_comb begin
    state_next      = state;
    req_ready       = 1'b0;
    resp_valid      = 1'b0;
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    mem_address     = '0;
    mem_wdata       = '0;
    mem_byte_enable = '1;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          case (req_op)
            LDW, LDB: state_next = READ;
            STW, STB: state_next = WRITE;
            LDI, STI: state_next = PTR_RD;
            default:  state_next = IDLE;
          endcase
        end
      end
      PTR_RD: begin
        mem_read    = 1'b1;
        mem_address = word_align(addr_r);
        if (mem_resp) state_next = (op_r == LDI) ? READ : WRITE;
      end
      READ: begin
        mem_read    = 1'b1;
        mem_address = tgt_addr;
        if (mem_resp) state_next = DONE;
      end
      WRITE: begin
        mem_write       = 1'b1;
        mem_address     = tgt_addr;
        mem_wdata       = lane_store;
        mem_byte_enable = lane_be;
        if (mem_resp) state_next = DONE;
      end
      DONE: begin
        resp_valid = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_lc3b_mem_unit.sv
// Self-checking bench for lc3b_mem_unit: table of single accesses, indirect and abort sequences, WIDTH=32 byte lanes.
module tb_lc3b_mem_unit;
  import lc3b_types::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // 16-bit instance
  logic        req_valid = 1'b0, req_ready, resp_valid;
  lc3b_memop   req_op = LDW;
  logic [15:0] req_addr = '0, req_wdata = '0, resp_rdata;
  logic [15:0] mem_address, mem_wdata, mem_rdata;
  logic        mem_read, mem_write, mem_resp;
  logic [1:0]  mem_byte_enable;

  lc3b_mem_unit #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_byte_enable(mem_byte_enable), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  // 32-bit instance
  logic        req_valid32 = 1'b0, req_ready32, resp_valid32;
  lc3b_memop   req_op32 = LDW;
  logic [31:0] req_addr32 = '0, req_wdata32 = '0, resp_rdata32;
  logic [31:0] mem_address32, mem_wdata32, mem_rdata32 = '0;
  logic        mem_read32, mem_write32, mem_resp32 = 1'b0;
  logic [3:0]  mem_byte_enable32;

  lc3b_mem_unit #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .req_valid(req_valid32), .req_ready(req_ready32),
    .req_op(req_op32), .req_addr(req_addr32), .req_wdata(req_wdata32),
    .resp_valid(resp_valid32), .resp_rdata(resp_rdata32),
    .mem_address(mem_address32), .mem_read(mem_read32), .mem_write(mem_write32),
    .mem_byte_enable(mem_byte_enable32), .mem_wdata(mem_wdata32),
    .mem_rdata(mem_rdata32), .mem_resp(mem_resp32)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [15:0] rdata;
    int          acc;
    int          lat;
  } exp_t;

  typedef struct {
    logic [15:0] addr;
    logic        we;
    logic [15:0] wdata;
    logic [1:0]  be;
    int          cycles;
  } access_t;

  exp_t        exp_q[$];
  access_t     log_q[$];
  logic [15:0] rd_q[$];
  int          wait_q[$];

  // Memory responder: each access pops its wait count; reads return queued data.
  initial begin
    bit busy = 0;
    int cnt = 0;
    int cur_wait = 0;
    mem_resp  = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_resp) busy = 0;
      mem_resp = 1'b0;
      if (rst || !(mem_read || mem_write)) begin
        busy = 0;
        cnt  = 0;
      end else begin
        if (!busy) begin
          busy = 1;
          cnt  = 0;
          cur_wait = (wait_q.size() > 0) ? wait_q.pop_front() : 0;
        end
        if (cnt == cur_wait) begin
          mem_resp = 1'b1;
          if (mem_read) mem_rdata = (rd_q.size() > 0) ? rd_q.pop_front() : 16'h0000;
          log_q.push_back('{addr: mem_address, we: mem_write, wdata: mem_wdata,
                            be: mem_byte_enable, cycles: cnt + 1});
        end else begin
          cnt++;
        end
      end
    end
  end

  // Response monitor / scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (resp_valid === 1'b1) begin
        chk("strobes_low_in_done", 32'({mem_read, mem_write}), 32'd0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_resp actual=resp_valid required=no response (t=%0t)", $time);
        end else begin
          e = exp_q.pop_front();
          chk("resp_rdata", 32'(resp_rdata), 32'(e.rdata));
          chk("latency", 32'(cyc - e.acc), 32'(e.lat));
        end
      end
    end
  end

  task automatic issue(input lc3b_memop op, input logic [15:0] addr, input logic [15:0] wd,
                       output int acc);
    @(negedge clk);
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wd;
    acc       = cyc;
    @(negedge clk);
    req_valid = 1'b0;
    req_op    = STW;
    req_addr  = 16'($urandom);
    req_wdata = 16'($urandom);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL resp_timeout actual=no resp_valid required=resp_valid within 60 cycles");
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic chk_access(input string name, input logic [15:0] addr, input logic we,
                            input logic [15:0] wd, input logic [1:0] be, input int cycles);
    access_t a;
    if (log_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_missing actual=no access required=access at %h", name, addr);
    end else begin
      a = log_q.pop_front();
      chk({name, "_addr"}, 32'(a.addr), 32'(addr));
      chk({name, "_we"}, 32'(a.we), 32'(we));
      chk({name, "_cycles"}, 32'(a.cycles), 32'(cycles));
      if (we) begin
        chk({name, "_wdata"}, 32'(a.wdata), 32'(wd));
        chk({name, "_be"}, 32'(a.be), 32'(be));
      end
    end
  endtask

  typedef struct {
    lc3b_memop   op;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rd;
    int          waits;
    logic [15:0] e_addr;
    logic [15:0] e_wdata;
    logic [1:0]  e_be;
    logic [15:0] e_rdata;
    int          e_lat;
  } vec_t;

  initial begin
    vec_t        vt[8];
    logic [15:0] last_load;
    int          acc;
    bit          is_load;

    vt[0] = '{LDW, 16'h3001, 16'h0000, 16'hBEEF, 3, 16'h3000, 16'h0000, 2'b11, 16'hBEEF, 5};
    vt[1] = '{LDB, 16'h3001, 16'h0000, 16'h8012, 0, 16'h3001, 16'h0000, 2'b11, 16'hFF80, 2};
    vt[2] = '{LDB, 16'h3000, 16'h0000, 16'h8012, 0, 16'h3000, 16'h0000, 2'b11, 16'h0012, 2};
    vt[3] = '{STB, 16'h4000, 16'h12AB, 16'h0000, 0, 16'h4000, 16'hABAB, 2'b01, 16'h0000, 2};
    vt[4] = '{STB, 16'h4001, 16'h00CD, 16'h0000, 1, 16'h4001, 16'hCDCD, 2'b10, 16'h0000, 3};
    vt[5] = '{STW, 16'h4003, 16'h1357, 16'h0000, 2, 16'h4002, 16'h1357, 2'b11, 16'h0000, 4};
    vt[6] = '{LDW, 16'h2000, 16'h0000, 16'h7F00, 0, 16'h2000, 16'h0000, 2'b11, 16'h7F00, 2};
    vt[7] = '{LDB, 16'h2001, 16'h0000, 16'h7F00, 0, 16'h2001, 16'h0000, 2'b11, 16'h007F, 2};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_rdata", 32'(resp_rdata), 32'd0);
    chk("rst_strobes", 32'({mem_read, mem_write}), 32'd0);
    chk("rst_mem_address", 32'(mem_address), 32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_byte_enable", 32'(mem_byte_enable), 32'h3);
    rst = 1'b0;
    last_load = 16'h0000;

    // Single-access vectors
    for (int i = 0; i < 8; i++) begin
      is_load = (vt[i].op == LDW) || (vt[i].op == LDB);
      if (is_load) rd_q.push_back(vt[i].rd);
      wait_q.push_back(vt[i].waits);
      issue(vt[i].op, vt[i].addr, vt[i].wdata, acc);
      if (is_load) last_load = vt[i].e_rdata;
      exp_q.push_back('{rdata: last_load, acc: acc, lat: vt[i].e_lat});
      wait_done();
      chk_access("vec", vt[i].e_addr, !is_load, vt[i].e_wdata, vt[i].e_be, vt[i].waits + 1);
    end

    // LDI: pointer read then word-aligned target read
    rd_q.push_back(16'h6003);
    rd_q.push_back(16'h1234);
    issue(LDI, 16'h5000, 16'h0000, acc);
    exp_q.push_back('{rdata: 16'h1234, acc: acc, lat: 3});
    wait_done();
    chk_access("ldi_ptr", 16'h5000, 1'b0, 16'h0, 2'b11, 1);
    chk_access("ldi_tgt", 16'h6002, 1'b0, 16'h0, 2'b11, 1);
    last_load = 16'h1234;

    // STI aborted by reset during the target write
    wait_q.push_back(0);
    wait_q.push_back(20);
    rd_q.push_back(16'h7005);
    issue(STI, 16'h5001, 16'hA5A5, acc);
    for (int i = 0; i < 10 && mem_write !== 1'b1; i++) @(negedge clk);
    chk("sti_mem_write", 32'(mem_write), 32'd1);
    chk("sti_address", 32'(mem_address), 32'h7004);
    chk("sti_wdata", 32'(mem_wdata), 32'hA5A5);
    chk("sti_be", 32'(mem_byte_enable), 32'h3);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_mem_write", 32'(mem_write), 32'd0);
    chk("abort_mem_read", 32'(mem_read), 32'd0);
    chk("abort_req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    chk("abort_resp_rdata", 32'(resp_rdata), 32'd0);
    log_q.delete();
    wait_q.delete();
    rd_q.delete();
    rd_q.push_back(16'h4321);
    issue(LDW, 16'h3002, 16'h0000, acc);
    exp_q.push_back('{rdata: 16'h4321, acc: acc, lat: 2});
    wait_done();
    chk_access("post_abort", 16'h3002, 1'b0, 16'h0, 2'b11, 1);

    // WIDTH=32 byte store and byte load
    @(negedge clk);
    req_valid32 = 1'b1; req_op32 = STB; req_addr32 = 32'h103; req_wdata32 = 32'h5A;
    @(negedge clk);
    req_valid32 = 1'b0;
    chk("w32_mem_write", 32'(mem_write32), 32'd1);
    chk("w32_address", mem_address32, 32'h103);
    chk("w32_be", 32'(mem_byte_enable32), 32'h8);
    chk("w32_wdata", mem_wdata32, 32'h5A5A5A5A);
    mem_resp32 = 1'b1;
    @(negedge clk);
    mem_resp32 = 1'b0;
    chk("w32_st_resp_valid", 32'(resp_valid32), 32'd1);
    @(negedge clk);
    req_valid32 = 1'b1; req_op32 = LDB; req_addr32 = 32'h102;
    @(negedge clk);
    req_valid32 = 1'b0;
    chk("w32_mem_read", 32'(mem_read32), 32'd1);
    chk("w32_ld_address", mem_address32, 32'h102);
    mem_rdata32 = 32'h0080_0000;
    mem_resp32  = 1'b1;
    @(negedge clk);
    mem_resp32 = 1'b0;
    chk("w32_ld_resp_valid", 32'(resp_valid32), 32'd1);
    chk("w32_ld_rdata", resp_rdata32, 32'hFFFF_FF80);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
